// File: rtl/bus_width_increase.sv
// Narrow-to-wide stream packer: little-endian lanes, one held output word.
// Optional early close via input_last/output_keep under BUS_WIDTH_INCREASE_LAST_EN.
module bus_width_increase #(
   parameter int SIZE_IN  = 8,
   parameter int SIZE_OUT = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        input_valid,
   output logic                        input_ready,
   input  logic [SIZE_IN-1:0]          data_in,
`ifdef BUS_WIDTH_INCREASE_LAST_EN
   input  logic                        input_last,
   output logic                        output_last,
   output logic [SIZE_OUT/SIZE_IN-1:0] output_keep,
`endif
   output logic                        output_valid,
   input  logic                        output_ready,
   output logic [SIZE_OUT-1:0]         data_out
);

   localparam int RATIO = SIZE_OUT / SIZE_IN;
   localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

   if ((SIZE_OUT % SIZE_IN) != 0 || RATIO < 2) begin : g_bad_ratio
      $error("bus_width_increase: SIZE_OUT must be a multiple >= 2 of SIZE_IN");
   end

   logic [CW-1:0]       cnt;
   logic [SIZE_OUT-1:0] acc;
   logic [SIZE_OUT-1:0] word;
   logic                full_beat;
   logic                close;
   logic                accept;

   assign full_beat = (cnt == CW'(RATIO - 1));

`ifdef BUS_WIDTH_INCREASE_LAST_EN
   logic [RATIO-1:0] keep_next;

   always_comb begin
      keep_next = '0;
      for (int k = 0; k < RATIO; k++)
         keep_next[k] = (CW'(k) <= cnt);
   end

   assign close = full_beat | input_last;
`else
   assign close = full_beat;
`endif

   // Stall only the beat that would need the output register while it is still owned.
   assign input_ready = ~(close & output_valid & ~output_ready);
   assign accept      = input_valid & input_ready;

   // Unfilled lanes stay zero because the accumulator is cleared on every close.
   always_comb begin
      word = acc;
      word[cnt*SIZE_IN +: SIZE_IN] = data_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         acc <= '0;
      end else if (accept) begin
         if (close) begin
            cnt <= '0;
            acc <= '0;
         end else begin
            cnt <= cnt + 1'b1;
            acc <= word;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         output_valid <= 1'b0;
         data_out     <= '0;
`ifdef BUS_WIDTH_INCREASE_LAST_EN
         output_last  <= 1'b0;
         output_keep  <= '0;
`endif
      end else if (accept && close) begin
         output_valid <= 1'b1;
         data_out     <= word;
`ifdef BUS_WIDTH_INCREASE_LAST_EN
         output_last  <= input_last;
         output_keep  <= keep_next;
`endif
      end else if (output_ready) begin
         output_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bus_width_increase.sv
// Directed and randomised-stream checks for bus_width_increase (8 -> 32).
// Early-close tests are built only with BUS_WIDTH_INCREASE_LAST_EN.
module tb_bus_width_increase;

   logic        clk = 1'b0;
   logic        reset;
   logic        input_valid;
   logic        input_ready;
   logic [7:0]  data_in;
   logic        output_valid;
   logic        output_ready;
   logic [31:0] data_out;
`ifdef BUS_WIDTH_INCREASE_LAST_EN
   logic        input_last;
   logic        output_last;
   logic [3:0]  output_keep;
`endif

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   bus_width_increase #(.SIZE_IN(8), .SIZE_OUT(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .input_valid  (input_valid),
      .input_ready  (input_ready),
      .data_in      (data_in),
`ifdef BUS_WIDTH_INCREASE_LAST_EN
      .input_last   (input_last),
      .output_last  (output_last),
      .output_keep  (output_keep),
`endif
      .output_valid (output_valid),
      .output_ready (output_ready),
      .data_out     (data_out)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      input_valid  = 1'b0;
      data_in      = 8'h00;
      output_ready = 1'b0;
`ifdef BUS_WIDTH_INCREASE_LAST_EN
      input_last   = 1'b0;
`endif
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (output_valid !== 1'b0)
         $display("FAIL rst_valid got=%b exp=0", output_valid);
      else passed++;
      checks++;
      if (data_out !== 32'h0)
         $display("FAIL rst_data got=%h exp=0", data_out);
      else passed++;
      checks++;
      if (input_ready !== 1'b1)
         $display("FAIL rst_ready got=%b exp=1", input_ready);
      else passed++;
   endtask

   task automatic test_basic();
      logic [7:0] b [4];
      b = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_reset();
      output_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         input_valid = 1'b1;
         data_in     = b[i];
         #1;
         checks++;
         if (input_ready !== 1'b1)
            $display("FAIL basic_ready%0d got=%b exp=1", i, input_ready);
         else passed++;
         if (i == 3) begin
            checks++;
            if (output_valid !== 1'b0)
               $display("FAIL basic_early got=%b exp=0", output_valid);
            else passed++;
         end
         @(posedge clk);
         #1;
      end
      input_valid = 1'b0;
      checks++;
      if (output_valid !== 1'b1)
         $display("FAIL basic_valid got=%b exp=1", output_valid);
      else passed++;
      checks++;
      if (data_out !== 32'h44332211)
         $display("FAIL basic_data got=%h exp=44332211", data_out);
      else passed++;
      tick();
      checks++;
      if (output_valid !== 1'b0)
         $display("FAIL basic_drain got=%b exp=0", output_valid);
      else passed++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      output_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         input_valid = 1'b1;
         data_in     = 8'(i);
         #1;
         checks++;
         if (input_ready !== 1'b1)
            $display("FAIL b2b_ready%0d got=%b exp=1", i, input_ready);
         else passed++;
         @(posedge clk);
         #1;
         if (i == 4) begin
            checks++;
            if (output_valid !== 1'b1 || data_out !== 32'h04030201)
               $display("FAIL b2b_w0 got=%b/%h exp=1/04030201",
                        output_valid, data_out);
            else passed++;
         end
      end
      input_valid = 1'b0;
      checks++;
      if (output_valid !== 1'b1 || data_out !== 32'h08070605)
         $display("FAIL b2b_w1 got=%b/%h exp=1/08070605",
                  output_valid, data_out);
      else passed++;
   endtask

   task automatic test_idle_gaps();
      do_reset();
      output_ready = 1'b1;
      input_valid  = 1'b1;
      data_in      = 8'h11;
      tick();
      input_valid = 1'b0;
      data_in     = 8'hEE;
      tick();
      tick();
      tick();
      checks++;
      if (output_valid !== 1'b0)
         $display("FAIL idle_valid got=%b exp=0", output_valid);
      else passed++;
      input_valid = 1'b1;
      data_in = 8'h22; tick();
      data_in = 8'h33; tick();
      data_in = 8'h44; tick();
      input_valid = 1'b0;
      checks++;
      if (output_valid !== 1'b1 || data_out !== 32'h44332211)
         $display("FAIL idle_data got=%b/%h exp=1/44332211",
                  output_valid, data_out);
      else passed++;
   endtask

   task automatic test_stall();
      do_reset();
      output_ready = 1'b0;
      input_valid  = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         data_in = 8'(i);
         tick();
      end
      data_in = 8'h08;
      #1;
      checks++;
      if (input_ready !== 1'b0)
         $display("FAIL stall_ready got=%b exp=0", input_ready);
      else passed++;
      tick();
      checks++;
      if (output_valid !== 1'b1 || data_out !== 32'h04030201)
         $display("FAIL stall_hold got=%b/%h exp=1/04030201",
                  output_valid, data_out);
      else passed++;
      checks++;
      if (input_ready !== 1'b0)
         $display("FAIL stall_ready2 got=%b exp=0", input_ready);
      else passed++;
      output_ready = 1'b1;
      #1;
      checks++;
      if (input_ready !== 1'b1)
         $display("FAIL stall_release got=%b exp=1", input_ready);
      else passed++;
      checks++;
      if (data_out !== 32'h04030201)
         $display("FAIL stall_w0 got=%h exp=04030201", data_out);
      else passed++;
      tick();
      input_valid = 1'b0;
      checks++;
      if (output_valid !== 1'b1 || data_out !== 32'h08070605)
         $display("FAIL stall_w1 got=%b/%h exp=1/08070605",
                  output_valid, data_out);
      else passed++;
      tick();
      checks++;
      if (output_valid !== 1'b0)
         $display("FAIL stall_drain got=%b exp=0", output_valid);
      else passed++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      output_ready = 1'b0;
      input_valid  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         data_in = 8'(i);
         tick();
      end
      data_in = 8'hAA; tick();
      data_in = 8'hBB; tick();
      input_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (output_valid !== 1'b0 || data_out !== 32'h0)
         $display("FAIL mid_async got=%b/%h exp=0/0",
                  output_valid, data_out);
      else passed++;
      checks++;
      if (input_ready !== 1'b1)
         $display("FAIL mid_ready got=%b exp=1", input_ready);
      else passed++;
      tick();
      reset = 1'b0;
      tick();
      output_ready = 1'b1;
      input_valid  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         data_in = 8'(i);
         tick();
      end
      input_valid = 1'b0;
      checks++;
      if (output_valid !== 1'b1 || data_out !== 32'h04030201)
         $display("FAIL mid_data got=%b/%h exp=1/04030201",
                  output_valid, data_out);
      else passed++;
   endtask

   task automatic test_random_stream();
      logic [31:0] expq [$];
      logic [31:0] acc_m;
      logic [31:0] e;
      int lane;
      int sent;
      int words;
      int cyc;
      do_reset();
      acc_m = '0;
      lane  = 0;
      sent  = 0;
      words = 0;
      cyc   = 0;
      while ((sent < 100 || expq.size() != 0) && cyc < 3000) begin
         input_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
         data_in      = 8'($urandom);
         output_ready = (cyc % 5 == 0);
         @(negedge clk);
         if (output_valid && output_ready) begin
            checks++;
            if (expq.size() == 0) begin
               $display("FAIL rand_extra got=%h exp=none", data_out);
            end else begin
               e = expq.pop_front();
               if (data_out !== e)
                  $display("FAIL rand_word%0d got=%h exp=%h",
                           words, data_out, e);
               else passed++;
            end
            words++;
         end
         if (input_valid && input_ready) begin
            acc_m[lane*8 +: 8] = data_in;
            lane++;
            sent++;
            if (lane == 4) begin
               expq.push_back(acc_m);
               acc_m = '0;
               lane  = 0;
            end
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      input_valid = 1'b0;
      checks++;
      if (words !== 25 || expq.size() != 0)
         $display("FAIL rand_count got=%0d exp=25 left=%0d cyc=%0d",
                  words, expq.size(), cyc);
      else passed++;
   endtask

`ifdef BUS_WIDTH_INCREASE_LAST_EN
   task automatic test_last_early();
      do_reset();
      output_ready = 1'b1;
      input_valid  = 1'b1;
      data_in = 8'h10; tick();
      data_in = 8'h20; tick();
      data_in = 8'h30;
      input_last = 1'b1;
      tick();
      input_valid = 1'b0;
      input_last  = 1'b0;
      checks++;
      if (data_out !== 32'h00302010)
         $display("FAIL last_data got=%h exp=00302010", data_out);
      else passed++;
      checks++;
      if (output_keep !== 4'b0111 || output_last !== 1'b1)
         $display("FAIL last_flags got=%b/%b exp=0111/1",
                  output_keep, output_last);
      else passed++;
   endtask

   task automatic test_last_stall();
      do_reset();
      output_ready = 1'b0;
      input_valid  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         data_in = 8'(8'hA0 + i);
         tick();
      end
      checks++;
      if (output_keep !== 4'hF || output_last !== 1'b0)
         $display("FAIL lstall_full got=%b/%b exp=1111/0",
                  output_keep, output_last);
      else passed++;
      data_in    = 8'h55;
      input_last = 1'b1;
      #1;
      checks++;
      if (input_ready !== 1'b0)
         $display("FAIL lstall_ready got=%b exp=0", input_ready);
      else passed++;
      tick();
      checks++;
      if (input_ready !== 1'b0 || data_out !== 32'hA4A3A2A1)
         $display("FAIL lstall_hold got=%b/%h exp=0/a4a3a2a1",
                  input_ready, data_out);
      else passed++;
      output_ready = 1'b1;
      #1;
      checks++;
      if (input_ready !== 1'b1)
         $display("FAIL lstall_rel got=%b exp=1", input_ready);
      else passed++;
      tick();
      input_valid = 1'b0;
      input_last  = 1'b0;
      checks++;
      if (data_out !== 32'h00000055 || output_keep !== 4'b0001 ||
          output_last !== 1'b1)
         $display("FAIL lstall_word got=%h/%b/%b exp=00000055/0001/1",
                  data_out, output_keep, output_last);
      else passed++;
   endtask
`endif

   initial begin
      reset = 1'b1;
      test_reset();
      test_basic();
      test_back_to_back();
      test_idle_gaps();
      test_stall();
      test_reset_mid();
      test_random_stream();
`ifdef BUS_WIDTH_INCREASE_LAST_EN
      test_last_early();
      test_last_stall();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
